// File: rtl/ir_loader_pkg.sv
// Shared types and defaults for the IR image loader.
package ir_loader_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_REQ   = 2'd1,
    LDR_WRITE = 2'd2,
    LDR_DONE  = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/ir_loader.sv
// Copies DEPTH instruction words from memory (starting at BASE_ADDR) into the IR regfile.
// Optional running checksum of the written words: define IR_LOADER_CHECKSUM_EN.
module ir_loader
  import ir_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_rf_we,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  output logic [DATA_WIDTH-1:0] o_rf_data,
  output logic                  o_busy,
  output logic                  o_init_finished
`ifdef IR_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] o_checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  ldr_state_t            state;
  logic [ADDR_WIDTH-1:0] idx;

  // Address simply increments per word, so BASE_ADDR+idx wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= LDR_IDLE;
      idx             <= '0;
      o_mem_req       <= 1'b0;
      o_mem_addr      <= '0;
      o_rf_we         <= 1'b0;
      o_rf_addr       <= '0;
      o_rf_data       <= '0;
      o_busy          <= 1'b0;
      o_init_finished <= 1'b0;
`ifdef IR_LOADER_CHECKSUM_EN
      o_checksum      <= '0;
`endif
    end else begin
      o_rf_we <= 1'b0;
      case (state)
        LDR_IDLE, LDR_DONE: begin
          if (i_start) begin
            state           <= LDR_REQ;
            idx             <= '0;
            o_mem_addr      <= BASE_ADDR;
            o_mem_req       <= 1'b1;
            o_busy          <= 1'b1;
            o_init_finished <= 1'b0;
`ifdef IR_LOADER_CHECKSUM_EN
            o_checksum      <= '0;
`endif
          end
        end
        LDR_REQ: begin
          if (i_mem_ack) begin
            state     <= LDR_WRITE;
            o_mem_req <= 1'b0;
            o_rf_we   <= 1'b1;
            o_rf_addr <= idx;
            o_rf_data <= i_mem_data;
`ifdef IR_LOADER_CHECKSUM_EN
            o_checksum <= o_checksum + i_mem_data;
`endif
          end
        end
        LDR_WRITE: begin
          if (idx == LAST_IDX) begin
            state           <= LDR_DONE;
            o_busy          <= 1'b0;
            o_init_finished <= 1'b1;
          end else begin
            state      <= LDR_REQ;
            idx        <= idx + 1'b1;
            o_mem_addr <= o_mem_addr + 1'b1;
            o_mem_req  <= 1'b1;
          end
        end
        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_loader.sv
// Self-checking bench for ir_loader: two instances (plain base and wrapping base) fed by a random memory image.
module tb_ir_loader;

  localparam int          DW    = 8;
  localparam int          AW    = 8;
  localparam int          DEPTH = 4;
  localparam logic [7:0]  BASE0 = 8'h10;
  localparam logic [7:0]  BASE1 = 8'hFE;

  logic       clk = 1'b0;
  logic       rst;
  logic       start    [2];
  logic       ack      [2];
  logic       mem_req  [2];
  logic       rf_we    [2];
  logic       busy     [2];
  logic       fin      [2];
  logic [7:0] mem_data [2];
  logic [7:0] mem_addr [2];
  logic [7:0] rf_addr  [2];
  logic [7:0] rf_data  [2];
`ifdef IR_LOADER_CHECKSUM_EN
  logic [7:0] checksum [2];
`endif
  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ir_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE0)) dut (
    .clk(clk), .rst(rst), .i_start(start[0]),
    .o_mem_req(mem_req[0]), .o_mem_addr(mem_addr[0]),
    .i_mem_ack(ack[0]), .i_mem_data(mem_data[0]),
    .o_rf_we(rf_we[0]), .o_rf_addr(rf_addr[0]), .o_rf_data(rf_data[0]),
    .o_busy(busy[0]), .o_init_finished(fin[0])
`ifdef IR_LOADER_CHECKSUM_EN
    , .o_checksum(checksum[0])
`endif
  );

  ir_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE1)) dut_wrap (
    .clk(clk), .rst(rst), .i_start(start[1]),
    .o_mem_req(mem_req[1]), .o_mem_addr(mem_addr[1]),
    .i_mem_ack(ack[1]), .i_mem_data(mem_data[1]),
    .o_rf_we(rf_we[1]), .o_rf_addr(rf_addr[1]), .o_rf_data(rf_data[1]),
    .o_busy(busy[1]), .o_init_finished(fin[1])
`ifdef IR_LOADER_CHECKSUM_EN
    , .o_checksum(checksum[1])
`endif
  );

  function automatic logic [7:0] baseOf(input int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input int k, input string tag);
    checkOutput({tag, ".mem_req"},  32'(mem_req[k]),  32'(0));
    checkOutput({tag, ".mem_addr"}, 32'(mem_addr[k]), 32'(0));
    checkOutput({tag, ".rf_we"},    32'(rf_we[k]),    32'(0));
    checkOutput({tag, ".rf_addr"},  32'(rf_addr[k]),  32'(0));
    checkOutput({tag, ".rf_data"},  32'(rf_data[k]),  32'(0));
    checkOutput({tag, ".busy"},     32'(busy[k]),     32'(0));
    checkOutput({tag, ".fin"},      32'(fin[k]),      32'(0));
`ifdef IR_LOADER_CHECKSUM_EN
    checkOutput({tag, ".checksum"}, 32'(checksum[k]), 32'(0));
`endif
  endtask

  task automatic fillMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  // Pulse start for one cycle; entered and left on a falling edge.
  task automatic applyStimulus(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Drives the memory side and compares each write against the image the load should produce.
  task automatic runLoad(input int k, input int stallWord, input int stallCycles,
                         input bit pokes, input int abortWord);
    int         wr      = 0;
    int         stalled = 0;
    int         finCyc  = -1;
    logic [7:0] sum     = 8'h00;
    logic [7:0] expAddr;
    applyStimulus(k);
    checkOutput("start.busy", 32'(busy[k]), 32'(1));
    checkOutput("start.fin",  32'(fin[k]),  32'(0));
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (fin[k]) begin
        finCyc = cyc;
        break;
      end
      start[k] = pokes && (cyc == 4);
      expAddr  = baseOf(k) + 8'(wr);
      if (rf_we[k]) begin
        checkOutput("write.idx",  32'(rf_addr[k]), 32'(wr));
        checkOutput("write.data", 32'(rf_data[k]), 32'(mem[expAddr]));
        checkOutput("write.noreq", 32'(mem_req[k]), 32'(0));
        sum         = sum + mem[expAddr];
        wr++;
        ack[k]      = pokes;
        mem_data[k] = 8'($urandom);
      end else if (mem_req[k]) begin
        if (wr == abortWord) begin
          ack[k]   = 1'b0;
          start[k] = 1'b0;
          return;
        end
        checkOutput("req.addr", 32'(mem_addr[k]), 32'(expAddr));
        if (wr == stallWord && stalled < stallCycles) begin
          stalled++;
          ack[k] = 1'b0;
        end else begin
          ack[k]      = 1'b1;
          mem_data[k] = mem[mem_addr[k]];
        end
      end else begin
        ack[k] = 1'b0;
      end
      @(negedge clk);
    end
    ack[k]   = 1'b0;
    start[k] = 1'b0;
    checkOutput("done.latency", 32'(finCyc), 32'(2 * DEPTH + 1 + stallCycles));
    checkOutput("done.words",   32'(wr),     32'(DEPTH));
    checkOutput("done.busy",    32'(busy[k]), 32'(0));
    checkOutput("done.req",     32'(mem_req[k]), 32'(0));
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      checkOutput("done.hold", 32'(fin[k]), 32'(1));
`ifdef IR_LOADER_CHECKSUM_EN
      checkOutput("done.checksum", 32'(checksum[k]), 32'(sum));
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; ack[k] = 1'b0; mem_data[k] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    checkIdle(0, "reset0");
    checkIdle(1, "reset1");
    rst = 1'b0;

    $display("[TB] stray ack while idle");
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    @(negedge clk);
    checkOutput("stray.req",  32'(mem_req[0]), 32'(0));
    checkOutput("stray.busy", 32'(busy[0]),    32'(0));

    $display("[TB] basic load");
    fillMem();
    runLoad(0, -1, 0, 1'b0, -1);

    $display("[TB] stalled ack on word 2, restart from done");
    fillMem();
    runLoad(0, 2, 5, 1'b0, -1);

    $display("[TB] wrapping base with stray acks and ignored start");
    fillMem();
    runLoad(1, 1, 2, 1'b1, -1);

    $display("[TB] mid-load reset");
    fillMem();
    runLoad(0, -1, 0, 1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    checkIdle(0, "midreset0");
    checkIdle(1, "midreset1");
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("postreset.busy", 32'(busy[0]), 32'(0));

    $display("[TB] reload after reset");
    fillMem();
    runLoad(0, -1, 0, 1'b1, -1);

`ifdef IR_LOADER_CHECKSUM_EN
    $display("[TB] checksum of known words");
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'hFF; mem[8'h13] = 8'h10;
    runLoad(0, -1, 0, 1'b0, -1);
    checkOutput("checksum.known", 32'(checksum[0]), 32'(8'h12));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
